// File: rtl/aes_iter_core.sv
// Iterative AES encryption core for AES-128/192/256 (NK = 4/6/8): one full round per clock
// over an externally loaded round-key bank. Define AES_ZEROIZE_EN to add the i_zeroize port.
module aes_iter_core #(
    parameter int NK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_plaintext,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_ciphertext,
    input  logic         i_rk_we,
    input  logic [3:0]   i_rk_idx,
    input  logic [127:0] i_rk_data,
`ifdef AES_ZEROIZE_EN
    input  logic         i_zeroize,
`endif
    output logic         o_rk_err
);
    localparam int NR = NK + 6;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] OUT   = 2'd2;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    generate
        if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
            $error("aes_iter_core: NK must be 4, 6 or 8");
        end
    endgenerate

    logic [1:0]   fsm;
    logic [3:0]   rnd;
    logic [127:0] blk;
    logic [127:0] rk [NR+1];
    logic [127:0] shifted;
    logic [127:0] mixed;
    logic [127:0] next_blk;
    logic         last;
    logic         accept;
    logic         wr_ok;
    logic         zero;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[(255 - int'(x)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

`ifdef AES_ZEROIZE_EN
    assign zero = i_zeroize;
`else
    assign zero = 1'b0;
`endif

    assign o_ready = (fsm == IDLE) && !rst;
    assign o_valid = (fsm == OUT);
    assign accept  = i_valid && o_ready;
    assign wr_ok   = i_rk_we && (fsm == IDLE) && (int'(i_rk_idx) <= NR);
    assign last    = (rnd == 4'(NR));

    // Byte i of the block is state[i%4][i/4]; ShiftRows rotates row r left by r columns.
    always_comb begin
        shifted = '0;
        mixed   = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127 - 8*(4*c + r) -: 8] = sbox(blk[127 - 8*(4*((c + r) % 4) + r) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32*c -: 32] = mix_col(shifted[127 - 32*c -: 32]);
        end
        next_blk = (last ? shifted : mixed) ^ rk[rnd];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm          <= IDLE;
            rnd          <= '0;
            blk          <= '0;
            o_ciphertext <= '0;
        end else if (zero) begin
            fsm          <= IDLE;
            rnd          <= '0;
            blk          <= '0;
            o_ciphertext <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (accept) begin
                        blk <= i_plaintext ^ rk[0];
                        rnd <= 4'd1;
                        fsm <= ROUND;
                    end
                end
                ROUND: begin
                    blk <= next_blk;
                    if (last) begin
                        o_ciphertext <= next_blk;
                        fsm          <= OUT;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                OUT: begin
                    if (i_ready) fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    // The starting block reads rk[0] combinationally, so a same-cycle write to it lands afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
            o_rk_err <= 1'b0;
        end else if (zero) begin
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
            o_rk_err <= 1'b0;
        end else begin
            if (wr_ok) rk[i_rk_idx] <= i_rk_data;
            o_rk_err <= i_rk_we && !wr_ok;
        end
    end
endmodule

// File: tb/tb_aes_iter_core.sv
// Scoreboard bench for aes_iter_core: three instances (NK = 4/6/8) driven with FIPS-197 vectors,
// round keys expanded by the bench itself; AES_ZEROIZE_EN also exercises i_zeroize.
module tb_aes_iter_core;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         vld   [3];
    logic         rdy_o [3];
    logic [127:0] pt    [3];
    logic         ovld  [3];
    logic         ird   [3];
    logic [127:0] ct    [3];
    logic         we    [3];
    logic [3:0]   idx   [3];
    logic [127:0] rkd   [3];
    logic         rkerr [3];
`ifdef AES_ZEROIZE_EN
    logic         zer   [3];
`endif

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_iter_core #(.NK(4 + 2*g)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .i_valid     (vld[g]),
            .o_ready     (rdy_o[g]),
            .i_plaintext (pt[g]),
            .o_valid     (ovld[g]),
            .i_ready     (ird[g]),
            .o_ciphertext(ct[g]),
            .i_rk_we     (we[g]),
            .i_rk_idx    (idx[g]),
            .i_rk_data   (rkd[g]),
`ifdef AES_ZEROIZE_EN
            .i_zeroize   (zer[g]),
`endif
            .o_rk_err    (rkerr[g])
        );
    end

    localparam logic [255:0] KEY_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_C8 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] DELTA = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // GF(2^8) arithmetic used to derive the S-box independently of any table.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] inv, y;
        inv = 8'h01;
        y   = x;
        for (int i = 1; i < 8; i++) begin
            y   = gmul(y, y);
            inv = gmul(inv, y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
    endfunction

    function automatic logic [127:0] round_key(input logic [255:0] key, input int nk, input int r);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

`ifdef AES_ZEROIZE_EN
    function automatic logic [127:0] model_zero_keys(input logic [127:0] p, input int nr);
        logic [127:0] s, t;
        logic [7:0]   a0, a1, a2, a3;
        s = p;
        for (int rd = 1; rd <= nr; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[127 - 8*(4*c + r) -: 8] = sb(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
            if (rd < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[127 - 32*c -: 8];
                    a1 = t[119 - 32*c -: 8];
                    a2 = t[111 - 32*c -: 8];
                    a3 = t[103 - 32*c -: 8];
                    t[127 - 32*c -: 32] = {gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3,
                                           a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3,
                                           a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3),
                                           gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3)};
                end
            end
            s = t;
        end
        return s;
    endfunction
`endif

    typedef struct {
        logic [127:0] ct;
        int           acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    function automatic void push(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop(input int d);
        case (d)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Monitor: every rising o_valid must match the oldest expected block, NR cycles after accept.
    logic prev_v [3] = '{1'b0, 1'b0, 1'b0};
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ovld[i] && !prev_v[i]) begin
                if (qsize(i) == 0) begin
                    check1($sformatf("unexpected_valid_%0d", i), ovld[i], 1'b0);
                end else begin
                    exp_t e;
                    e = pop(i);
                    check($sformatf("ciphertext_%0d", i), ct[i], e.ct);
                    check($sformatf("latency_%0d", i), 128'(cyc - e.acc), 128'(10 + 2*i));
                end
            end
            prev_v[i] = ovld[i];
        end
    end

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (!rdy_o[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check1("idle_wait", rdy_o[d], 1'b1);
    endtask

    task automatic wait_valid(input int d);
        int n;
        n = 0;
        while (!ovld[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check1("valid_wait", ovld[d], 1'b1);
    endtask

    task automatic load_keys(input int d, input logic [255:0] key, input int nk);
        wait_idle(d);
        for (int r = 0; r <= nk + 6; r++) begin
            we[d]  = 1'b1;
            idx[d] = 4'(r);
            rkd[d] = round_key(key, nk, r);
            @(negedge clk);
        end
        we[d] = 1'b0;
    endtask

    task automatic send(input int d, input logic [127:0] p, input logic [127:0] exp_ct,
                        input bit expect_out, output int acc);
        int   n;
        exp_t e;
        n      = 0;
        vld[d] = 1'b1;
        pt[d]  = p;
        while (!rdy_o[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check1("accept_wait", rdy_o[d], 1'b1);
        acc = cyc + 1;
        if (expect_out) begin
            e.ct  = exp_ct;
            e.acc = acc;
            push(d, e);
        end
        @(negedge clk);
        vld[d] = 1'b0;
        we[d]  = 1'b0;
    endtask

    task automatic key_write(input int d, input logic [3:0] i, input logic [127:0] data);
        we[d]  = 1'b1;
        idx[d] = i;
        rkd[d] = data;
        @(negedge clk);
        we[d]  = 1'b0;
    endtask

    initial begin
        int acc;
        int k;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b0;
            pt[i]  = '0;
            ird[i] = 1'b1;
            we[i]  = 1'b0;
            idx[i] = '0;
            rkd[i] = '0;
`ifdef AES_ZEROIZE_EN
            zer[i] = 1'b0;
`endif
        end
        repeat (3) @(negedge clk);
        check1("rst_o_ready", rdy_o[0], 1'b0);
        check1("rst_o_valid", ovld[0], 1'b0);
        check("rst_o_ciphertext", ct[0], 128'h0);
        check1("rst_o_rk_err", rkerr[0], 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check1("ready_after_rst", rdy_o[0], 1'b1);

        // FIPS-197 App. B and App. C vectors for all key sizes
        load_keys(0, KEY_B, 4);
        send(0, PT_B, CT_B, 1'b1, acc);
        load_keys(1, KEY_C, 6);
        send(1, PT_C, CT_C6, 1'b1, acc);
        load_keys(2, KEY_C, 8);
        send(2, PT_C, CT_C8, 1'b1, acc);
        load_keys(0, KEY_C, 4);
        send(0, PT_C, CT_C4, 1'b1, acc);

        // Backpressure: hold the result for 7 cycles, then release with the next block waiting
        wait_idle(0);
        ird[0] = 1'b0;
        send(0, PT_C, CT_C4, 1'b1, acc);
        wait_valid(0);
        for (int i = 0; i < 7; i++) begin
            check1("hold_o_valid", ovld[0], 1'b1);
            check("hold_o_ciphertext", ct[0], CT_C4);
            check1("hold_o_ready", rdy_o[0], 1'b0);
            @(negedge clk);
        end
        ird[0] = 1'b1;
        k = cyc;
        send(0, PT_C, CT_C4, 1'b1, acc);
        check("accept_after_transfer", 128'(acc - k), 128'd2);

        // Rejected key writes: one during ROUND, one with index NR+1 in IDLE
        send(0, PT_C, CT_C4, 1'b1, acc);
        key_write(0, 4'd9, '1);
        check1("rk_err_in_round", rkerr[0], 1'b1);
        @(negedge clk);
        check1("rk_err_one_shot", rkerr[0], 1'b0);
        wait_idle(0);
        key_write(0, 4'd11, '1);
        check1("rk_err_bad_idx", rkerr[0], 1'b1);
        @(negedge clk);
        check1("rk_err_bad_idx_clear", rkerr[0], 1'b0);
        send(0, PT_C, CT_C4, 1'b1, acc);

        // Key write to rk[0] on the accept edge: this block uses the old key, the next the new
        wait_idle(0);
        we[0]  = 1'b1;
        idx[0] = 4'd0;
        rkd[0] = round_key(KEY_C, 4, 0) ^ DELTA;
        send(0, PT_C, CT_C4, 1'b1, acc);
        check1("rk_write_with_accept_ok", rkerr[0], 1'b0);
        send(0, PT_C ^ DELTA, CT_C4, 1'b1, acc);

        // Reset in round 5 aborts the block
        load_keys(0, KEY_B, 4);
        send(0, PT_B, '0, 1'b0, acc);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check1("midrst_o_ready", rdy_o[0], 1'b0);
        check1("midrst_o_valid", ovld[0], 1'b0);
        check("midrst_o_ciphertext", ct[0], 128'h0);
        check1("midrst_o_rk_err", rkerr[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (16) @(negedge clk);
        check1("midrst_idle", rdy_o[0], 1'b1);
        load_keys(0, KEY_B, 4);
        send(0, PT_B, CT_B, 1'b1, acc);

`ifdef AES_ZEROIZE_EN
        // Zeroize while holding a result, with a concurrent key write that must be ignored
        wait_idle(0);
        ird[0] = 1'b0;
        send(0, PT_B, CT_B, 1'b1, acc);
        wait_valid(0);
        zer[0] = 1'b1;
        key_write(0, 4'd1, '1);
        zer[0] = 1'b0;
        check1("zeroize_o_valid", ovld[0], 1'b0);
        check("zeroize_o_ciphertext", ct[0], 128'h0);
        check1("zeroize_no_rk_err", rkerr[0], 1'b0);
        ird[0] = 1'b1;
        send(0, PT_B, model_zero_keys(PT_B, 10), 1'b1, acc);
`endif

        for (int n = 0; n < 300 && (q0.size() + q1.size() + q2.size()) != 0; n++) @(negedge clk);
        check("scoreboard_drained", 128'(q0.size() + q1.size() + q2.size()), 128'd0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_iter_core.md
Name: aes_iter_core

Overview:
Iterative AES encryption core for all three FIPS-197 key sizes. It runs one full round per clock over a preloaded round-key bank and replaces the fixed AES-128 multi-stage-per-round FSM. Blocks enter and leave on valid/ready handshakes, and the output is held under backpressure. Round keys come from an external key-schedule block through a write port, so the core does no key expansion.

Parameters:
- NK, default 4: key length in 32-bit words. Legal values are 4, 6 and 8 (AES-128/192/256). Any other value is an elaboration error.
- NR, default NK+6: derived localparam, the number of rounds (10/12/14). It is not overridable.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- i_valid, input, 1: plaintext block present.
- o_ready, output, 1: core can accept a block.
- i_plaintext, input, 128: input block. Byte 0 is [127:120]. The state is loaded column-major per FIPS-197.
- o_valid, output, 1: ciphertext present.
- i_ready, input, 1: downstream accepts the ciphertext.
- o_ciphertext, output, 128: result, same byte order as the input.
- i_rk_we, input, 1: round-key write strobe.
- i_rk_idx, input, 4: round-key index, 0..NR.
- i_rk_data, input, 128: round key.
- o_rk_err, output, 1: one-cycle pulse when a key write is rejected.

Behaviour:
- Reset values: o_ready=0 during reset, 1 after it. o_valid=0, o_ciphertext=0, o_rk_err=0. Round counter=0. All key-bank entries=0. FSM=IDLE.
- Key bank: NR+1 registers of 128 bits.
  - A write with i_rk_we=1 is accepted only in IDLE and only when i_rk_idx<=NR.
  - Otherwise the write is dropped and o_rk_err pulses high the next cycle.
  - A write and an accept in the same IDLE cycle: the write lands, but the starting block uses the pre-write value of that entry.
- FSM states: IDLE, ROUND, OUT.
  - o_ready=1 only in IDLE. It is a combinational decode of the state.
- IDLE: on i_valid&&o_ready (accept edge E0):
  - state <= i_plaintext ^ rk[0]
  - rnd <= 1
  - go to ROUND
- ROUND, each edge:
  - If rnd<NR: state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk[rnd], then rnd <= rnd+1.
  - If rnd==NR: state <= ShiftRows(SubBytes(state)) ^ rk[NR] (no MixColumns), then go to OUT.
- Latency: o_valid rises NR edges after E0, i.e. 10/12/14 cycles.
- OUT:
  - o_valid=1 and o_ciphertext=state, both stable while i_ready=0.
  - On i_ready=1, the block transfers and the FSM goes to IDLE.
  - Minimum spacing between accepts is NR+2 cycles.
- o_ciphertext keeps the last result after leaving OUT. It is only meaningful while o_valid=1.
- i_valid held in ROUND or OUT is ignored, with no queuing. The upstream block holds its data until o_ready=1.
- SubBytes uses a combinational forward S-box. ROM or composite-field implementation is free, but there are no clock stages inside a round.
- MixColumns is GF(2^8) with polynomial 0x11B.
- rnd is 4 bits and never exceeds NR. It does not wrap.
- rst mid-operation: abort the block immediately, clear the key bank, return to IDLE, and produce no o_valid.

Optional Feature:
- Macro: AES_ZEROIZE_EN.
- When the macro is defined, a port i_zeroize (input, 1) is added.
  - In any state, when i_zeroize=1 on an edge: the key bank, state and o_ciphertext are cleared to 0, an in-flight block is dropped, and the FSM goes to IDLE.
  - o_valid is 0 from the next cycle.
  - Key writes in the same cycle are ignored, and o_rk_err is not raised for them.
- When the macro is undefined, the port is absent and only rst clears state.

Test Plan:
- NK=4, FIPS-197 App. B. Load the expanded keys from key 2b7e151628aed2a6abf7158809cf4f3c, send pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32, with o_valid exactly 10 cycles after accept.
- NK=4/6/8, FIPS-197 App. C. Key 000102..(16/24/32 bytes), pt 00112233445566778899aabbccddeeff:
  - NK=4 -> 69c4e0d86a7b0430d8cdb78070b4c55a, latency 10.
  - NK=6 -> dda97ca4864cdfe06eaf70a0ec0d7191, latency 12.
  - NK=8 -> 8ea2b7ca516745bfeafc49904b496089, latency 14.
- Backpressure: hold i_ready=0 for 7 cycles in OUT -> o_valid and o_ciphertext stay constant, and o_ready=0 throughout. Then raise i_ready with i_valid already high -> the next block is accepted 2 cycles after the transfer.
- Rejected key writes: a write in ROUND, and a write with i_rk_idx=NR+1 in IDLE -> o_rk_err pulses once for each, and the bank is unchanged (checked by the next ciphertext matching the expected value).
- Reset mid-block: assert rst at round 5 -> all outputs return to reset values and no o_valid appears. After reloading keys, App. B gives the correct ct.
- AES_ZEROIZE_EN: pulse i_zeroize while in OUT -> o_valid=0 next cycle and o_ciphertext=0. A block encrypted afterwards without reloading keys gives SubBytes/ShiftRows/MixColumns output with all-zero round keys (bench model comparison).
